// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//
// This module is a registered N-to-2^N one-hot decoder with an enable input.
// It has two modes of operation:
//   - Direct mode decodes the address input. The output follows one clock
//     later.
//   - Scan mode runs an autonomous sequencer. The sequencer steps the one-hot
//     output through every code, starting at addr. Each code is held for
//     dwell+1 cycles.
//
// Typical uses are row and digit selects for LED matrices, multiplexed
// 7-segment displays and keypad scanners.
//
// Configuration macro:
//   SCAN_DECODER_ACTIVE_LOW_EN - When defined, dout is the bitwise inverse
//                                of the one-hot vector. Inactive means
//                                all-ones, and exactly one bit is low when a
//                                code is active. cur_addr, busy and wrap are
//                                not affected.
//
// Parameters:
//   ADDR_W   - Address width. The output width OUT_W = 2**ADDR_W.
//   DWELL_W  - Width of the dwell input and of the internal dwell counter.
//
// Ports:
//   clk       in   Rising-edge system clock.
//   rst_n     in   Asynchronous active-low reset.
//   enable    in   Global enable. When 0, all outputs are forced inactive.
//   mode      in   0 = direct decode, 1 = scan.
//   addr      in   Direct-mode address. In scan mode, the start index.
//   start     in   Single-cycle pulse that begins a scan.
//   stop      in   Single-cycle pulse that aborts a scan.
//   dwell     in   Extra cycles to hold each code while scanning.
//   dout      out  Registered one-hot output. Polarity depends on the macro.
//   cur_addr  out  Index currently asserted on dout.
//   busy      out  High while scanning.
//   wrap      out  One-cycle pulse when the scan wraps from OUT_W-1 to 0.
// ---------------------------------------------------------------------------
module scan_decoder #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**ADDR_W-1:0] dout,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 busy,
  output logic                 wrap
);

  localparam int OUT_W = 2**ADDR_W;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] POL_MASK = '1;
`else
  localparam logic [OUT_W-1:0] POL_MASK = '0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_dout;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic               r_busy;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;

  state_t             w_state_next;
  logic [OUT_W-1:0]   w_onehot_next;
  logic [ADDR_W-1:0]  w_cur_addr_next;
  logic               w_busy_next;
  logic               w_wrap_next;
  logic [DWELL_W-1:0] w_cnt_next;
  logic [DWELL_W-1:0] w_dwell_next;
  logic [ADDR_W-1:0]  w_step_addr;

  // The next scan index wraps naturally because it is ADDR_W bits wide.
  assign w_step_addr = r_cur_addr + 1'b1;

  // State and output registers.
  // The output polarity is applied before the register, so dout comes
  // straight from a flop in both builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dout     <= POL_MASK;
      r_cur_addr <= '0;
      r_busy     <= 1'b0;
      r_wrap     <= 1'b0;
      r_cnt      <= '0;
      r_dwell    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_dout     <= w_onehot_next ^ POL_MASK;
      r_cur_addr <= w_cur_addr_next;
      r_busy     <= w_busy_next;
      r_wrap     <= w_wrap_next;
      r_cnt      <= w_cnt_next;
      r_dwell    <= w_dwell_next;
    end
  end

  // Next-state and next-output logic.
  // The outputs computed here are the values the registers present after
  // the coming edge. That is why a transition into DIRECT or SCAN loads the
  // decoded address on the same edge that changes state.
  always_comb begin
    w_state_next    = r_state;
    w_onehot_next   = '0;
    w_cur_addr_next = r_cur_addr;
    w_busy_next     = 1'b0;
    w_wrap_next     = 1'b0;
    w_cnt_next      = r_cnt;
    w_dwell_next    = r_dwell;

    case (r_state)
      IDLE: begin
        if (enable && !mode) begin
          w_state_next    = DIRECT;
          w_onehot_next   = OUT_W'(1) << addr;
          w_cur_addr_next = addr;
        end else if (enable && mode && start && !stop) begin
          // dwell is captured only here. Later changes wait for the next
          // start.
          w_state_next    = SCAN;
          w_onehot_next   = OUT_W'(1) << addr;
          w_cur_addr_next = addr;
          w_cnt_next      = dwell;
          w_dwell_next    = dwell;
          w_busy_next     = 1'b1;
        end
      end

      DIRECT: begin
        if (!enable || mode) begin
          w_state_next = IDLE;
        end else begin
          w_onehot_next   = OUT_W'(1) << addr;
          w_cur_addr_next = addr;
        end
      end

      SCAN: begin
        // While scanning, mode changes and further start pulses have no
        // effect. Only stop or a dropped enable end the scan.
        if (stop || !enable) begin
          w_state_next = IDLE;
        end else begin
          w_busy_next = 1'b1;
          if (r_cnt != '0) begin
            w_cnt_next    = r_cnt - 1'b1;
            w_onehot_next = OUT_W'(1) << r_cur_addr;
          end else begin
            w_cur_addr_next = w_step_addr;
            w_onehot_next   = OUT_W'(1) << w_step_addr;
            w_cnt_next      = r_dwell;
            w_wrap_next     = (w_step_addr == '0);
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign dout     = r_dout;
  assign cur_addr = r_cur_addr;
  assign busy     = r_busy;
  assign wrap     = r_wrap;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable. Successor to the combinational 4x16 decoder.
- Two modes: direct decode of an input address, and an autonomous scan sequencer. The scan sequencer steps the one-hot output through all codes, holding each code for a programmable dwell.
- Drives row/digit selects for LED-matrix, 7-seg multiplexing and keypad scanning blocks in the lab designs.

Parameters:
- ADDR_W, 4, address width; output width is OUT_W = 2**ADDR_W (derived localparam, not overridable).
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global enable; 0 forces all outputs inactive.
- mode  in  1  0 = direct decode, 1 = scan.
- addr  in  ADDR_W  direct-mode address; start index in scan mode.
- start  in  1  single-cycle pulse; begins a scan (mode=1 only).
- stop  in  1  single-cycle pulse; aborts a scan.
- dwell  in  DWELL_W  extra cycles to hold each code; each code is held dwell+1 cycles.
- dout  out  OUT_W  registered one-hot decode output.
- cur_addr  out  ADDR_W  index currently asserted on dout.
- busy  out  1  high while in SCAN.
- wrap  out  1  one-cycle pulse when the scan wraps from OUT_W-1 to 0.

Behaviour:
- Reset is asynchronous and active-low: one clock; rst_n low clears immediately regardless of clk.
- Reset values: dout=0, cur_addr=0, busy=0, wrap=0, state=IDLE, dwell counter=0.
- Reset asserted mid-scan aborts immediately. After release the block stays in IDLE until new stimulus arrives.
- States: IDLE, DIRECT, SCAN.
- IDLE:
  - dout=0.
  - enable=1 & mode=0 -> DIRECT.
  - enable=1 & mode=1 & start=1 & stop=0 -> SCAN.
- DIRECT:
  - Each cycle, dout <= 1<<addr and cur_addr <= addr. Latency is 1 clock from addr to dout.
  - enable=0 or mode=1 -> IDLE, with dout=0 on the next edge.
- SCAN entry (on the start edge):
  - cur_addr <= addr, dout <= 1<<addr, counter <= dwell, busy <= 1.
  - dwell is sampled only at start; later changes are ignored until the next start.
- SCAN stepping, each cycle:
  - If counter != 0: decrement the counter.
  - Else: cur_addr <= cur_addr+1 (modulo OUT_W), dout follows, counter <= sampled dwell.
  - dwell=0 steps every cycle.
- Wrap: when cur_addr steps from OUT_W-1 to 0, wrap=1 for exactly the cycle in which dout first shows bit 0.
- SCAN exit: stop=1 or enable=0 -> IDLE on that edge; dout=0, busy=0, wrap=0 on the next cycle.
- Mode changes during SCAN are ignored.
- start during SCAN is ignored; there is no restart.
- start and stop asserted in the same cycle: stop wins. From IDLE the block remains in IDLE.
- start with mode=0 or enable=0 is ignored.
- dout is always one-hot or all-zero (active-high build); never multi-hot.

Optional Feature:
- Macro: SCAN_DECODER_ACTIVE_LOW_EN.
- Defined: dout is the bitwise inverse of the one-hot vector. The reset value and all inactive states are all-ones, and exactly one bit is low when active (74HC154 style). cur_addr, busy and wrap are unaffected.
- Undefined: active-high as described above.

Test Plan:
- Reset and direct decode: assert rst_n=0 mid-cycle -> dout=0 immediately; release, enable=1, mode=0, addr=4'hA -> dout=16'h0400, cur_addr=10 one clock later.
- Direct sweep: sweep addr 0..15 with enable=1, then enable=0 -> dout=1<<addr each cycle with 1-clock latency; enable=0 -> dout=16'h0000 next cycle.
- Scan with dwell: mode=1, addr=14, dwell=2, start pulse -> dout holds 16'h4000 for 3 cycles, then 16'h8000 for 3 cycles, then 16'h0001 with wrap=1 for one cycle; busy=1 throughout.
- Scan at full speed: dwell=0, addr=0, start -> dout steps every cycle; wrap pulses every 16 cycles.
- Abort and collision: stop mid-scan -> dout=0, busy=0 next cycle; start+stop together in IDLE -> stays IDLE, dout=0; rst_n low mid-scan -> all outputs 0 immediately.
- Active-low build (macro defined), addr=3 direct -> dout=16'hFFF7; reset value 16'hFFFF.
